// File: rtl/if_id_fetch_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// slave: seen from the fetch stage. master: seen from the surrounding pipeline.
interface if_id_fetch_stage_if #(
  parameter int XLEN = 32
);
  // Hazard-unit holds and ID/EX redirect
  logic            PCWrite;
  logic            IF_ID_Write;
  logic            Redirect;
  logic [XLEN-1:0] Redirect_Target;

  // Instruction memory
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] imem_addr;

  // Fetch PC and IF/ID register contents
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] IF_ID_PC4;
  logic [XLEN-1:0] IF_ID_Instr;
  logic            IF_ID_Valid;
  logic [4:0]      IF_ID_RegisterRs;
  logic [4:0]      IF_ID_RegisterRt;
  logic [15:0]     Stall_Count;

  modport slave (
    input  PCWrite, IF_ID_Write, Redirect, Redirect_Target,
    input  imem_ready, imem_rdata,
    output imem_addr, PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
    output IF_ID_RegisterRs, IF_ID_RegisterRt, Stall_Count
  );

  modport master (
    output PCWrite, IF_ID_Write, Redirect, Redirect_Target,
    output imem_ready, imem_rdata,
    input  imem_addr, PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
    input  IF_ID_RegisterRs, IF_ID_RegisterRt, Stall_Count
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives imem_addr, and latches {PC+4, instr, valid} into IF/ID.
// Redirect beats both holds; PC and IF/ID holds act independently, so a held
// PC with IF/ID loading fetches (and duplicates) the same word again.
module if_id_fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
  input  logic                CLK,
  input  logic                RST,
  if_id_fetch_stage_if.slave  bus
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [15:0]     STALL_MAX  = 16'hFFFF;

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] pc4_q,   pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [15:0]     stall_q, stall_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;

  // Wraps naturally at 2^XLEN; target is forced to a word boundary.
  assign pc_plus4       = pc_q + PC_STEP;
  assign target_aligned = bus.Redirect_Target & ALIGN_MASK;

  // Next-state selection in priority order: redirect, then independent PC / IF-ID updates.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    stall_d = stall_q;

    if (bus.Redirect) begin
      pc_d    = target_aligned;
      pc4_d   = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      if (!bus.PCWrite && bus.imem_ready) begin
        pc_d = pc_plus4;
      end
      if (!bus.IF_ID_Write) begin
        if (bus.imem_ready) begin
          pc4_d   = pc_plus4;
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
        end else begin
          pc4_d   = '0;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    end

    // A redirect edge is not counted as a hold even if PCWrite is up.
    if (bus.PCWrite && !bus.Redirect && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers; reset discards any in-flight fetch or stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  // Only the address and register-field taps are combinational.
  assign bus.imem_addr        = pc_q;
  assign bus.PC               = pc_q;
  assign bus.IF_ID_PC4        = pc4_q;
  assign bus.IF_ID_Instr      = instr_q;
  assign bus.IF_ID_Valid      = valid_q;
  assign bus.IF_ID_RegisterRs = instr_q[25:21];
  assign bus.IF_ID_RegisterRt = instr_q[20:16];
  assign bus.Stall_Count      = stall_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: table of per-edge vectors with expected
// post-edge state pushed to a scoreboard queue, plus hand sequences for
// asynchronous reset and Stall_Count saturation.
module tb_if_id_fetch_stage;

  logic clk;
  logic rst;

  if_id_fetch_stage_if #(.XLEN(32)) bus ();

  if_id_fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Instruction memory: the word at address a is 0xC0DE_0000 + a.
  assign bus.imem_rdata = 32'hC0DE_0000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] stall;
  } exp_t;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        redir;
    logic [31:0] tgt;
    logic        ready;
    exp_t        e;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  exp_t sb_q [$];

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    logic [31:0] ins;
    ins = e.instr;
    check({tag, " PC"},        bus.PC,               e.pc);
    check({tag, " imem_addr"}, bus.imem_addr,        e.pc);
    check({tag, " PC4"},       bus.IF_ID_PC4,        e.pc4);
    check({tag, " Instr"},     bus.IF_ID_Instr,      e.instr);
    check({tag, " Valid"},     32'(bus.IF_ID_Valid), 32'(e.valid));
    check({tag, " Rs"},        32'(bus.IF_ID_RegisterRs), 32'(ins[25:21]));
    check({tag, " Rt"},        32'(bus.IF_ID_RegisterRt), 32'(ins[20:16]));
    check({tag, " Stall"},     32'(bus.Stall_Count), 32'(e.stall));
  endtask

  exp_t rst_exp;
  exp_t got;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_exp = '{32'h0, 32'h0, 32'h0, 1'b0, 16'd0};

    //             pcw ifw rdr target         rdy   {pc,           pc4,          instr,        v,    stall}
    vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'h4,       32'h4,        32'hC0DE0000, 1'b1, 16'd0}};
    vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'h8,       32'h8,        32'hC0DE0004, 1'b1, 16'd0}};
    vecs[2]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1, '{32'h8,       32'h8,        32'hC0DE0004, 1'b1, 16'd1}};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'hC,       32'hC,        32'hC0DE0008, 1'b1, 16'd1}};
    vecs[4]  = '{1'b1,1'b0,1'b1,32'h100,      1'b1, '{32'h100,     32'h0,        32'h0,        1'b0, 16'd1}};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'h104,     32'h104,      32'hC0DE0100, 1'b1, 16'd1}};
    vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0, '{32'h104,     32'h0,        32'h0,        1'b0, 16'd1}};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0, '{32'h104,     32'h0,        32'h0,        1'b0, 16'd1}};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'h108,     32'h108,      32'hC0DE0104, 1'b1, 16'd1}};
    vecs[9]  = '{1'b0,1'b0,1'b1,32'h103,      1'b1, '{32'h100,     32'h0,        32'h0,        1'b0, 16'd1}};
    vecs[10] = '{1'b0,1'b0,1'b1,32'hFFFFFFFC, 1'b0, '{32'hFFFFFFFC,32'h0,        32'h0,        1'b0, 16'd1}};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b1, '{32'h0,       32'h0,        32'hC0DDFFFC, 1'b1, 16'd1}};
    vecs[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b1, '{32'h0,       32'h4,        32'hC0DE0000, 1'b1, 16'd2}};
    vecs[13] = '{1'b1,1'b0,1'b0,32'h0,        1'b1, '{32'h0,       32'h4,        32'hC0DE0000, 1'b1, 16'd3}};
    vecs[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b1, '{32'h4,       32'h4,        32'hC0DE0000, 1'b1, 16'd3}};
    vecs[15] = '{1'b1,1'b1,1'b0,32'h0,        1'b0, '{32'h4,       32'h4,        32'hC0DE0000, 1'b1, 16'd4}};
    vecs[16] = '{1'b1,1'b1,1'b0,32'h0,        1'b1, '{32'h4,       32'h4,        32'hC0DE0000, 1'b1, 16'd5}};

    rst = 1'b1;
    bus.PCWrite         = 1'b0;
    bus.IF_ID_Write     = 1'b0;
    bus.Redirect        = 1'b0;
    bus.Redirect_Target = 32'h0;
    bus.imem_ready      = 1'b1;

    // Reset state, held across a couple of edges
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", rst_exp);
    @(negedge clk);
    rst = 1'b0;

    // Table: drive while clk is low, push expectation, compare 1 after the edge
    for (int i = 0; i < NV; i++) begin
      bus.PCWrite         = vecs[i].pcw;
      bus.IF_ID_Write     = vecs[i].ifw;
      bus.Redirect        = vecs[i].redir;
      bus.Redirect_Target = vecs[i].tgt;
      bus.imem_ready      = vecs[i].ready;
      sb_q.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check_state($sformatf("vec%0d", i), got);
      @(negedge clk);
    end

    // Asynchronous reset mid-stall: takes effect without a clock edge
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    bus.imem_ready  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", rst_exp);
    @(negedge clk);
    rst = 1'b0;

    // Saturation of Stall_Count under a sustained PC hold
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    check("stall_fffe", 32'(bus.Stall_Count), 32'h0000_FFFE);
    @(posedge clk);
    #1;
    check("stall_ffff", 32'(bus.Stall_Count), 32'h0000_FFFF);
    for (int i = 0; i < 4465; i++) @(posedge clk);
    #1;
    check("stall_sat",  32'(bus.Stall_Count), 32'h0000_FFFF);
    check("stall_pc",   bus.PC,               32'h0);
    check("stall_valid", 32'(bus.IF_ID_Valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
